// File: rtl/key_event_arbiter.sv
// Debounces N_CH level inputs into press/release events and merges them onto one
// valid/ready event stream. A fair round-robin arbiter picks the channel.
module key_event_arbiter #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 19,
    parameter bit REPORT_RELEASE  = 1'b0,
    localparam int CW             = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_CH-1:0] in,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [CW-1:0]   ev_chan,
    output logic            ev_press,
    output logic [N_CH-1:0] stable,
    output logic [N_CH-1:0] overrun,
    input  logic [N_CH-1:0] overrun_clr
);

    localparam logic [7:0] TC = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0]      cnt [N_CH];
    logic [N_CH-1:0] slot_full;
    logic [N_CH-1:0] slot_type;
    logic [N_CH-1:0] raise;
    logic [N_CH-1:0] granted;
    logic [N_CH-1:0] drop;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   grant_idx;
    logic [CW-1:0]   rr_next;
    logic            found;
    logic            grant;
    logic            loadable;
    int unsigned     idx;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            raise[i] = (in[i] != stable[i]) && (cnt[i] == TC) && (in[i] || REPORT_RELEASE);
        end
    end

    assign loadable = !ev_valid || ev_ready;

    // Walk the ring backwards so the slot closest to rr_ptr is the last one written.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = (32'(rr_ptr) + 32'(k)) % 32'(N_CH);
            if (slot_full[idx]) begin
                found     = 1'b1;
                grant_idx = CW'(idx);
            end
        end
        grant = found && loadable;
    end

    assign rr_next = (grant_idx == CW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            granted[i] = grant && (grant_idx == CW'(i));
            drop[i]    = raise[i] && slot_full[i] && !granted[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
            stable    <= '0;
            slot_full <= '0;
            slot_type <= '0;
            overrun   <= '0;
            rr_ptr    <= '0;
            ev_valid  <= 1'b0;
            ev_chan   <= '0;
            ev_press  <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (in[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TC) begin
                    stable[i] <= in[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end

                // A slot freed by this edge's grant can take a new event at once.
                if (raise[i] && !drop[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_type[i] <= in[i];
                end else if (granted[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end

            overrun <= (overrun & ~overrun_clr) | drop;

            if (loadable) begin
                if (grant) begin
                    ev_valid <= 1'b1;
                    ev_chan  <= grant_idx;
                    ev_press <= slot_type[grant_idx];
                    rr_ptr   <= rr_next;
                end else begin
                    ev_valid <= 1'b0;
                end
            end
        end
    end

endmodule
